// File: rtl/input_stream_fetch.sv
// input_stream_fetch: reads a length header from input SRAM, then streams the data words to the core
//   clk, reset                       : clock, asynchronous active-high reset
//   start, base_addr                 : fetch request and header address (taken only in IDLE)
//   busy, done, eod                  : fetch in progress, end-of-fetch pulse, end-of-data header seen
//   sram_read_address/sram_read_data : input SRAM read port (data one cycle after address)
//   out_data/out_valid/out_ready/out_last : valid/ready stream to the core, out_last on the final word
module input_stream_fetch #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done,
    output logic                  eod
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = 12;
    typedef enum logic [2:0] {IDLE, HDR_ISSUE, HDR_WAIT, STREAM, DRAIN, DONE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, nxt_q, nxt_d;
    logic [LW-1:0]         rem_q, rem_d;
    logic                  eod_q, eod_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q;
    logic [PW-1:0]         wp_q, rp_q;
    logic [CW-1:0]         cnt_q;
    logic                  issue, push, pop;
    // Throttle counts the read still in flight so a returning word always finds a free FIFO slot.
    assign issue = (state_q == STREAM) && (rem_q != '0) &&
                   (({1'b0, cnt_q} + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH));
    assign push = inflight_q;
    assign pop = out_valid & out_ready;
    assign out_valid = cnt_q != '0;
    assign out_data = out_valid ? fifo_data[rp_q] : '0;
    assign out_last = out_valid & last_q[rp_q];
    assign sram_read_address = issue ? nxt_q : addr_q;
    assign busy = (state_q == HDR_ISSUE) || (state_q == HDR_WAIT) || (state_q == STREAM) || (state_q == DRAIN);
    assign done = state_q == DONE;
    assign eod = eod_q;
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        nxt_d = nxt_q;
        rem_d = rem_q;
        eod_d = eod_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d = base_addr;
                nxt_d = base_addr + 1'b1;
                eod_d = 1'b0;
                state_d = HDR_ISSUE;
            end
            HDR_ISSUE: state_d = HDR_WAIT;
            HDR_WAIT: begin
                if (sram_read_data == '1) begin
                    eod_d = 1'b1;
                    state_d = DONE;
                end else if (sram_read_data[LW-1:0] == '0) begin
                    state_d = DONE;
                end else begin
                    rem_d = sram_read_data[LW-1:0];
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (issue) begin
                    addr_d = nxt_q;
                    nxt_d = nxt_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                end else if (rem_q == '0 && !inflight_q) begin
                    // The final word may already be accepted in the cycle it becomes visible.
                    state_d = (pop && out_last) ? DONE : DRAIN;
                end
            end
            DRAIN: if ((pop && out_last) || cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            nxt_q <= '0;
            rem_q <= '0;
            eod_q <= 1'b0;
            inflight_q <= 1'b0;
            last_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            nxt_q <= nxt_d;
            rem_q <= rem_d;
            eod_q <= eod_d;
            inflight_q <= issue;
            if (push) begin
                last_q[wp_q] <= rem_q == '0;
                wp_q <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo_data[wp_q] <= sram_read_data;
    end
endmodule

// File: tb/tb_input_stream_fetch.sv
// tb_input_stream_fetch: scoreboard bench for input_stream_fetch with a one-cycle-latency SRAM model
module tb_input_stream_fetch;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [11:0] base_addr = '0;
    logic        busy, out_valid, out_last, done, eod;
    logic [11:0] sram_read_address;
    logic [15:0] sram_read_data, out_data;
    logic [15:0] mem [4096];
    logic [16:0] q [$];
    logic [11:0] alog [$];
    logic [16:0] e;
    logic [15:0] pd;
    logic [11:0] paddr;
    int total = 0, bad = 0, cyc = 0, t0 = 0, done_cnt = 0, done_cyc = 0, acc = 0, last_acc = 0, max_out = 0, dc;
    bit first = 1'b0, stall = 1'b0, pbusy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) sram_read_data <= mem[sram_read_address];

    input_stream_fetch dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .busy(busy),
        .sram_read_address(sram_read_address), .sram_read_data(sram_read_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done), .eod(eod)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
            pbusy = 1'b0;
        end else begin
            if (busy && (!pbusy || sram_read_address != paddr)) alog.push_back(sram_read_address);
            pbusy = busy;
            paddr = sram_read_address;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 0);
            end
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 1);
                chk("hold_data", 64'(out_data), 64'(pd));
            end
            if (out_valid && first) begin
                chk("latency", 64'(cyc - t0), 4);
                first = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("data", 64'(out_data), 64'(e[15:0]));
                    chk("last", 64'(out_last), 64'(e[16]));
                end
                acc++;
                last_acc = cyc;
            end
            if (alog.size() > 1 && alog.size() - 1 - acc > max_out) max_out = alog.size() - 1 - acc;
            stall = out_valid && !out_ready;
            pd = out_data;
        end
    end

    task automatic load(input logic [11:0] b, input int n, input logic [15:0] v0, input logic [15:0] dv, input bit exp);
        mem[b] = 16'(n);
        for (int i = 1; i <= n; i++) begin
            logic [11:0] a;
            logic [15:0] v;
            a = b + 12'(i);
            v = v0 + 16'(i - 1) * dv;
            mem[a] = v;
            if (exp) q.push_back({i == n, v});
        end
    endtask

    task automatic go(input logic [11:0] b);
        alog.delete();
        acc = 0;
        max_out = 0;
        @(posedge clk);
        #1 base_addr = b;
        start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        start = 1'b0;
        first = 1'b1;
    endtask

    task automatic wait_done(input bit rnd, input int lim);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < lim) begin
            @(posedge clk);
            #1 out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        chk("done_seen", 64'(done_cnt != d0), 1);
        out_ready = 1'b1;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {busy, sram_read_address, out_valid, out_data, out_last, done, eod}, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 chk_outs_zero("reset_outs");
        reset = 1'b0;

        load(12'h010, 3, 16'h00A1, 16'h0111, 1'b1);
        go(12'h010);
        wait_done(1'b0, 100);
        chk("basic_last_cyc", 64'(last_acc - t0), 6);
        chk("basic_done_cyc", 64'(done_cyc - t0), 7);
        chk("basic_naddr", 64'(alog.size()), 4);
        for (int i = 0; i < 4 && i < alog.size(); i++) chk("basic_addr", 64'(alog[i]), 64'(12'h010 + i));
        chk("basic_eod", 64'(eod), 0);
        @(posedge clk);
        #1 chk("basic_busy_after", 64'(busy), 0);

        load(12'h010, 8, 16'h00A1, 16'h0111, 1'b1);
        go(12'h010);
        wait_done(1'b1, 400);
        chk("bp_beats", 64'(acc), 8);
        chk("bp_outstanding_ok", 64'(max_out <= 4), 1);
        chk("bp_queue_empty", 64'(q.size()), 0);

        mem[12'h100] = 16'h0000;
        go(12'h100);
        wait_done(1'b0, 20);
        chk("zero_done_cyc", 64'(done_cyc - t0), 2);
        chk("zero_beats", 64'(acc), 0);
        chk("zero_eod", 64'(eod), 0);

        mem[12'h100] = 16'hFFFF;
        go(12'h100);
        wait_done(1'b0, 20);
        chk("eod_done_cyc", 64'(done_cyc - t0), 2);
        chk("eod_beats", 64'(acc), 0);
        chk("eod_flag", 64'(eod), 1);

        load(12'hFFE, 2, 16'h0011, 16'h0011, 1'b1);
        go(12'hFFE);
        chk("wrap_eod_cleared", 64'(eod), 0);
        wait_done(1'b0, 100);
        chk("wrap_naddr", 64'(alog.size()), 3);
        if (alog.size() == 3) begin
            chk("wrap_addr0", 64'(alog[0]), 12'hFFE);
            chk("wrap_addr1", 64'(alog[1]), 12'hFFF);
            chk("wrap_addr2", 64'(alog[2]), 12'h000);
        end
        chk("wrap_beats", 64'(acc), 2);

        load(12'h010, 10, 16'h00A1, 16'h0111, 1'b1);
        go(12'h010);
        for (int n = 0; acc < 3 && n < 100; n++) @(posedge clk);
        chk("rst_three_beats", 64'(acc >= 3), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_outs_zero("rst_mid_outs");
        q.delete();
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("rst_no_done", 64'(done_cnt), 64'(dc));
        load(12'h020, 2, 16'h5555, 16'h5555, 1'b1);
        go(12'h020);
        wait_done(1'b0, 100);
        chk("rst_refetch_beats", 64'(acc), 2);
        chk("rst_refetch_queue", 64'(q.size()), 0);

        load(12'h010, 3, 16'h00A1, 16'h0111, 1'b1);
        load(12'h040, 2, 16'h4444, 16'h1111, 1'b0);
        dc = done_cnt;
        go(12'h010);
        @(posedge clk);
        #1 base_addr = 12'h040;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0, 100);
        repeat (10) @(posedge clk);
        #1 chk("sb_busy_idle", 64'(busy), 0);
        chk("sb_beats", 64'(acc), 3);
        chk("sb_done_once", 64'(done_cnt - dc), 1);
        chk("sb_first_addr", 64'(alog[0]), 12'h010);
        chk("sb_queue_empty", 64'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
